str_blit_ctrl: RTL and testbench

STR_BLIT_CTRL -- requirements
Module: str_blit_ctrl

---
 rtl/str_blit_ctrl.sv | 139 +++++++++++++
 tb/tb_str_blit_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/str_blit_ctrl.sv
// String blitter: walks a row of glyphs from a glyph ROM and emits one registered pixel per raster pixel.
// Optional STR_BLIT_SCALE2_EN doubles every glyph pixel horizontally and vertically.
module str_blit_ctrl #(
    parameter int width_p      = 32,
    parameter int rows_p       = 64,
    parameter int glyphs_p     = 4,
    parameter int addr_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    frame_start_i,
    input  logic                    enable_i,
    input  logic [9:0]              origin_x_i,
    input  logic [9:0]              origin_y_i,
    input  logic                    pix_en_i,
    input  logic [9:0]              x_i,
    input  logic [9:0]              y_i,
    output logic [addr_width_p-1:0] rom_addr_o,
    input  logic [width_p-1:0]      rom_data_i,
    output logic                    pixel_o,
    output logic                    active_o,
    output logic                    line_done_o
);

`ifdef STR_BLIT_SCALE2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int CW = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int GW = (glyphs_p > 1) ? $clog2(glyphs_p) : 1;
    localparam int RW = (rows_p   > 1) ? $clog2(rows_p)   : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(width_p - 1);
    localparam logic [GW-1:0] GLY_LAST = GW'(glyphs_p - 1);
    localparam logic [10:0]   Y_SPAN   = 11'(rows_p * S);

    typedef enum logic [1:0] {IDLE, ACTIVE, LINE_END} state_t;

    state_t          state_q;
    logic [9:0]      ox_q, oy_q;
    logic            en_q;
    logic [GW-1:0]   glyph_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;

    logic [9:0]      dy;
    logic            y_in, entry, is_act, emit;
    logic [RW-1:0]   row_y, cur_row;
    logic [GW-1:0]   cur_glyph, glyph_nxt;
    logic [CW-1:0]   cur_col, col_nxt;
    logic            col_step, col_wrap, last_pix, pix_bit;

    assign dy     = y_i - oy_q;
    assign y_in   = (y_i >= oy_q) && ({1'b0, dy} < Y_SPAN);
    assign row_y  = RW'(dy >> (S - 1));
    assign is_act = (state_q == ACTIVE);
    assign entry  = (state_q == IDLE) && pix_en_i && en_q && (x_i == ox_q) && y_in;
    assign emit   = pix_en_i && (is_act || entry);

    // Outside ACTIVE the counters read as zero so the ROM word for the first pixel is ready on the entry cycle.
    assign cur_glyph = is_act ? glyph_q : '0;
    assign cur_col   = is_act ? col_q   : '0;
    assign cur_row   = is_act ? row_q   : row_y;

    assign rom_addr_o = addr_width_p'(cur_glyph) * addr_width_p'(rows_p) + addr_width_p'(cur_row);

`ifdef STR_BLIT_SCALE2_EN
    logic sub_q;
    logic cur_sub;
    assign cur_sub  = is_act ? sub_q : 1'b0;
    assign col_step = cur_sub;
`else
    assign col_step = 1'b1;
`endif

    assign col_wrap  = col_step && (cur_col == COL_LAST);
    assign last_pix  = col_wrap && (cur_glyph == GLY_LAST);
    assign col_nxt   = !col_step ? cur_col : (col_wrap ? '0 : cur_col + CW'(1));
    assign glyph_nxt = col_wrap ? cur_glyph + GW'(1) : cur_glyph;
    assign pix_bit   = rom_data_i[COL_LAST - cur_col];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ox_q        <= '0;
            oy_q        <= '0;
            en_q        <= 1'b0;
            glyph_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pixel_o     <= 1'b0;
            active_o    <= 1'b0;
            line_done_o <= 1'b0;
`ifdef STR_BLIT_SCALE2_EN
            sub_q       <= 1'b0;
`endif
        end else if (frame_start_i) begin
            state_q     <= IDLE;
            ox_q        <= origin_x_i;
            oy_q        <= origin_y_i;
            en_q        <= enable_i;
            glyph_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pixel_o     <= 1'b0;
            active_o    <= 1'b0;
            line_done_o <= 1'b0;
`ifdef STR_BLIT_SCALE2_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            pixel_o     <= 1'b0;
            active_o    <= 1'b0;
            line_done_o <= 1'b0;
            if (emit) begin
                pixel_o  <= pix_bit;
                active_o <= 1'b1;
                if (!is_act)
                    row_q <= row_y;
                if (last_pix) begin
                    state_q <= LINE_END;
                    glyph_q <= '0;
                    col_q   <= '0;
                end else begin
                    state_q <= ACTIVE;
                    glyph_q <= glyph_nxt;
                    col_q   <= col_nxt;
                end
`ifdef STR_BLIT_SCALE2_EN
                sub_q <= last_pix ? 1'b0 : ~cur_sub;
`endif
            end else if (state_q == LINE_END) begin
                line_done_o <= 1'b1;
                state_q     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_str_blit_ctrl.sv
// Directed, table-driven bench for str_blit_ctrl with a behavioural glyph ROM.
// Honours STR_BLIT_SCALE2_EN the same way as the design.
module tb_str_blit_ctrl;

`ifdef STR_BLIT_SCALE2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int W    = 32;
    localparam int ROWS = 64;
    localparam int G    = 4;

    logic       clk = 1'b0;
    logic       reset, frame_start, enable, pix_en;
    logic [9:0] origin_x, origin_y, x, y;
    logic [7:0] rom_addr;
    logic [31:0] rom_data;
    logic       pixel, active, line_done;

    typedef struct {
        logic       rst, fs, fen;
        logic [9:0] fox, foy;
        logic       pe;
        logic [9:0] x, y;
        logic       ca;
        logic [7:0] ea;
        logic       ep, eact, eld;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    str_blit_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .frame_start_i(frame_start),
        .enable_i     (enable),
        .origin_x_i   (origin_x),
        .origin_y_i   (origin_y),
        .pix_en_i     (pix_en),
        .x_i          (x),
        .y_i          (y),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .pixel_o      (pixel),
        .active_o     (active),
        .line_done_o  (line_done)
    );

    function automatic logic [31:0] rom_word(input int a);
        if (a == 11)
            return 32'h7FC03FFF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign rom_data = rom_word(int'(rom_addr));

    task automatic push(input logic rst, fs, fen, input int fox, foy, input logic pe,
                        input int xx, yy, input logic ca, input int ea,
                        input logic ep, eact, eld);
        vec_t v;
        v.rst = rst; v.fs = fs; v.fen = fen;
        v.fox = 10'(fox); v.foy = 10'(foy);
        v.pe = pe; v.x = 10'(xx); v.y = 10'(yy);
        v.ca = ca; v.ea = 8'(ea);
        v.ep = ep; v.eact = eact; v.eld = eld;
        tbl.push_back(v);
    endtask

    // One raster line across the region; optional pix_en gap, mid-line frame_start, or x==ox during LINE_END.
    task automatic gen_line(input int ox, oy, en, yy, gap_at, gap_len, abort_at, input bit reentry);
        int row, total, g, col, ea;
        logic [31:0] w;
        bit in_reg;
        in_reg = (en != 0) && (yy >= oy) && (yy < oy + ROWS * S);
        row    = in_reg ? (yy - oy) / S : 0;
        total  = G * W * S;
        push(0, 0, 0, 0, 0, 1, ox - 1, yy, in_reg, row, 0, 0, 0);
        for (int k = 0; k < total; k++) begin
            g   = k / (W * S);
            col = (k / S) % W;
            ea  = g * ROWS + row;
            w   = rom_word(ea);
            if (k == gap_at)
                for (int j = 0; j < gap_len; j++)
                    push(0, 0, 0, 0, 0, 0, ox + k, yy, in_reg, ea, 0, 0, 0);
            if (k == abort_at) begin
                push(0, 1, 1, ox, oy, 1, ox + k, yy, 0, 0, 0, 0, 0);
                push(0, 0, 0, 0, 0, 1, ox + k + 1, yy, in_reg, row, 0, 0, 0);
                return;
            end
            push(0, 0, 0, 0, 0, 1, ox + k, yy, in_reg, ea, in_reg ? w[W-1-col] : 1'b0, in_reg, 0);
        end
        push(0, 0, 0, 0, 0, 1, reentry ? ox : ox + total, yy, 0, 0, 0, 0, in_reg);
        push(0, 0, 0, 0, 0, 1, ox + total + 1, yy, in_reg, row, 0, 0, 0);
    endtask

    task automatic check1(input string name, input int idx, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec %0d got %b want %b", name, idx, got, want);
        end
    endtask

    initial begin
        logic [31:0] w;
        int ry;
        vec_t v;

        reset = 1'b1; frame_start = 1'b0; enable = 1'b0; pix_en = 1'b0;
        origin_x = '0; origin_y = '0; x = '0; y = '0;

        push(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1, 1, 5, 5, 1, 5, 5, 0, 0, 0, 0, 0);
        push(0, 1, 1, 100, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        gen_line(100, 50, 1, 50, -1, 0, -1, 0);
        gen_line(100, 50, 1, 50 + 11 * S, -1, 0, -1, 0);
        gen_line(100, 50, 1, 52, 9, 5, -1, 0);
        gen_line(100, 50, 1, 53, -1, 0, 50, 0);
        gen_line(100, 50, 1, 50 + ROWS * S - 1, -1, 0, -1, 1);
        gen_line(100, 50, 1, 50 + ROWS * S, -1, 0, -1, 0);
        gen_line(100, 50, 1, 49, -1, 0, -1, 0);

        push(0, 1, 0, 100, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        gen_line(100, 50, 0, 60, -1, 0, -1, 0);

        push(0, 1, 1, 200, 300, 0, 0, 0, 0, 0, 0, 0, 0);
        gen_line(200, 300, 1, 305, 40, 3, -1, 0);

        // Reset beats a simultaneous frame_start and kills the line mid-flight.
        ry = 10 / S;
        w  = rom_word(ry);
        push(0, 0, 0, 0, 0, 1, 200, 310, 1, ry, w[31], 1, 0);
        push(1, 1, 1, 200, 310, 1, 201, 310, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        // Hand-computed: ROM word 11 = 0x7FC03FFF, MSB first.
        push(0, 1, 1, 100, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 100, 50 + 11 * S, 1, 11, 0, 1, 0);
        push(0, 0, 0, 0, 0, 1, 101, 50 + 11 * S, 1, 11, (S == 1) ? 1'b1 : 1'b0, 1, 0);
        push(0, 0, 0, 0, 0, 1, 102, 50 + 11 * S, 1, 11, 1, 1, 0);
        push(0, 1, 1, 100, 50, 1, 103, 50 + 11 * S, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 104, 50 + 11 * S, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            reset = v.rst; frame_start = v.fs; enable = v.fen;
            origin_x = v.fox; origin_y = v.foy;
            pix_en = v.pe; x = v.x; y = v.y;
            #1;
            if (v.ca) begin
                checks++;
                if (rom_addr !== v.ea) begin
                    errors++;
                    $display("FAIL rom_addr vec %0d got %0d want %0d", i, rom_addr, v.ea);
                end
            end
            @(negedge clk);
            check1("pixel", i, pixel, v.ep);
            check1("active", i, active, v.eact);
            check1("line_done", i, line_done, v.eld);
        end

        reset = 1'b0; frame_start = 1'b0; pix_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
